mac4_accum: RTL and testbench

MAC4_ACCUM -- requirements
Module: mac4_accum

---
 rtl/mac4_accum_pkg.sv | 13 +
 rtl/mac4_accum_if.sv | 30 +++
 rtl/mac4_accum_multi_4.sv | 22 ++
 rtl/mac4_accum.sv | 153 +++++++++++++++
 tb/tb_mac4_accum.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mac4_accum_pkg.sv
// Shared types and default sizes for the mac4_accum block.
package mac4_accum_pkg;

  localparam int ACC_W_DEF = 12;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/mac4_accum_if.sv
// Operand stream in, packet result out, for the 4x4 multiply-accumulate block.
interface mac4_accum_if
  import mac4_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/mac4_accum_multi_4.sv
// 4x4 unsigned array multiplier: one ripple row per multiplier bit.
module multi_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [4:0] row0;
  logic [4:0] row1;
  logic [4:0] row2;
  logic [4:0] row3;

  // Each row adds the next partial product to the upper bits of the row above;
  // the row's bit 0 is final and drops out as a product bit.
  assign row0 = {1'b0, a & {4{b[0]}}};
  assign row1 = {1'b0, row0[4:1]} + {1'b0, a & {4{b[1]}}};
  assign row2 = {1'b0, row1[4:1]} + {1'b0, a & {4{b[2]}}};
  assign row3 = {1'b0, row2[4:1]} + {1'b0, a & {4{b[3]}}};

  assign p = {row3, row2[0], row1[0], row0[0]};

endmodule

// File: rtl/mac4_accum.sv
// Three-stage multiply-accumulate over packets of 4-bit operand pairs.
// Result is held until the consumer takes it, then the next packet starts.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   ACC   | accepting beats; last beat accepted moves on
//   FLUSH | input closed, waiting for the last beat to land in the sum
//   HOLD  | result presented on out_*, waiting for out_ready
module mac4_accum
  import mac4_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic        clk,
  input logic        rst_n,
  mac4_accum_if.slave bus
);

  state_t           state;
  logic             rdy_q;
  logic             vld_q;
  logic             accept;
  logic             handshake;

  logic             s1_valid;
  logic             s1_last;
  logic [3:0]       s1_a;
  logic [3:0]       s1_b;
  logic [7:0]       mul_p;

  logic             s2_valid;
  logic             s2_last;
  logic [7:0]       s2_prod;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             s3_done;
  logic [ACC_W:0]   acc_sum;

  assign accept    = bus.in_valid & rdy_q;
  assign handshake = vld_q & bus.out_ready;

  // Extra top bit catches the carry out of the accumulator.
  assign acc_sum = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, s2_prod};

  multi_4 u_mul (
    .a (s1_a),
    .b (s1_b),
    .p (mul_p)
  );

  // Stage 1: capture the accepted operand beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= bus.in_a;
        s1_b    <= bus.in_b;
        s1_last <= bus.in_last;
      end
    end
  end

  // Stage 2: register the product from the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_prod <= mul_p;
        s2_last <= s1_last;
      end
    end
  end

  // Stage 3: accumulate, count terms, latch wrap; cleared when the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      s3_done <= 1'b0;
    end else begin
      s3_done <= s2_valid & s2_last;
      if (handshake) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (s2_valid) begin
        acc <= acc_sum[ACC_W-1:0];
        cnt <= cnt + 1'b1;
        if (acc_sum[ACC_W]) ovf <= 1'b1;
      end
    end
  end

  // Packet sequencing with registered in_ready/out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          vld_q <= 1'b0;
          if (accept && bus.in_last) begin
            state <= FLUSH;
            rdy_q <= 1'b0;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        FLUSH: begin
          rdy_q <= 1'b0;
          if (s3_done) begin
            state <= HOLD;
            vld_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state <= ACC;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state <= ACC;
          rdy_q <= 1'b0;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_sum   = acc;
  assign bus.out_count = cnt;
  assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_mac4_accum.sv
// Directed and randomized packets against a packet-level sum/count model.
module tb_mac4_accum;

  localparam int ACC_W = 12;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   last_acc_edge;

  int   cur_sum;
  int   cur_cnt;
  int   exp_sum[$];
  int   exp_cnt[$];
  int   exp_ovf[$];

  mac4_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  mac4_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with in_valid dropped.
  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic last,
                      input bit must_be_now);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_beat", bus.in_ready, 1);
    if (must_be_now) chk("accept_after_handshake_wait", n, 0);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    if (last) last_acc_edge = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    cur_sum += int'(a) * int'(b);
    cur_cnt += 1;
    if (last) begin
      exp_sum.push_back(cur_sum % (1 << ACC_W));
      exp_cnt.push_back(cur_cnt % (1 << CNT_W));
      exp_ovf.push_back(cur_sum >= (1 << ACC_W) ? 1 : 0);
      cur_sum = 0;
      cur_cnt = 0;
    end
  endtask

  task automatic get_result(input int hold, input bit tied);
    int n;
    int es;
    int ec;
    int eo;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_arrives", bus.out_valid, 1);
    if (!bus.out_valid) return;
    es = exp_sum.pop_front();
    ec = exp_cnt.pop_front();
    eo = exp_ovf.pop_front();
    chk("latency", cyc - last_acc_edge, 3);
    chk("out_sum", bus.out_sum, es);
    chk("out_count", bus.out_count, ec);
    chk("out_ovf", bus.out_ovf, eo);
    chk("in_ready_in_hold", bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_sum", bus.out_sum, es);
      chk("hold_count", bus.out_count, ec);
      chk("hold_ovf", bus.out_ovf, eo);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    if (!tied) bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!tied) bus.out_ready = 1'b0;
    chk("valid_drops_after_hs", bus.out_valid, 0);
    chk("ready_after_hs", bus.in_ready, 1);
  endtask

  initial begin
    int len;
    checks        = 0;
    errors        = 0;
    cur_sum       = 0;
    cur_cnt       = 0;
    last_acc_edge = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.in_ready, 1);

    // single beat 15*15
    beat(4'd15, 4'd15, 1'b1, 1'b0);
    get_result(0, 1'b0);

    // four beats with a bubble between beats 2 and 3
    beat(4'd3, 4'd5, 1'b0, 1'b0);
    beat(4'd2, 4'd7, 1'b0, 1'b0);
    @(negedge clk);
    beat(4'd15, 4'd1, 1'b0, 1'b0);
    beat(4'd0, 4'd9, 1'b1, 1'b0);
    get_result(0, 1'b0);

    // consumer stalls for 6 cycles, next packet goes straight in
    beat(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'b0, 1'b0);
    beat(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'b1, 1'b0);
    get_result(6, 1'b0);
    beat(4'd9, 4'd3, 1'b1, 1'b1);
    get_result(0, 1'b0);

    // accumulator wrap sets ovf; next packet starts clean
    for (int i = 0; i < 19; i++) beat(4'd15, 4'd15, (i == 18), 1'b0);
    get_result(0, 1'b0);
    beat(4'd1, 4'd1, 1'b1, 1'b0);
    get_result(0, 1'b0);

    // reset mid-packet discards the partial packet
    beat(4'd5, 4'd6, 1'b0, 1'b0);
    beat(4'd7, 4'd8, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_out_sum", bus.out_sum, 0);
    cur_sum = 0;
    cur_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(4'd4, 4'd4, 1'b1, 1'b0);
    get_result(0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_extra_result", bus.out_valid, 0);
    end

    // term counter wraps with no flag side effects on count
    for (int i = 0; i < 257; i++)
      beat(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), (i == 256), 1'b0);
    get_result(0, 1'b0);

    // random packets with random bubbles and stalls
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3, 0) == 0) @(negedge clk);
        beat(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), (i == len - 1), 1'b0);
      end
      get_result($urandom_range(3, 0), 1'b0);
    end

    // back-to-back single-beat packets, consumer always ready
    bus.out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      beat(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'b1, (p != 0));
      get_result(0, 1'b1);
    end
    bus.out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
